pipe_adder: RTL and testbench

Parametrised, pipelined N-bit adder built from registered carry-chain slices, with valid/ready flow control on both sides. It replaces single-bit combinational adder cells in datapaths that need wide operands at a clock rate a full-width ripple chain cannot meet. It sits between an operand producer and a result consumer, and accepts one operation per cycle when not back-pressured.

---
 rtl/pipe_adder_pkg.sv | 26 ++
 rtl/adder_slice.sv | 30 +++
 rtl/pipe_adder.sv | 157 +++++++++++++++
 tb/tb_pipe_adder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-slice adder: default geometry,
// the per-stage control record and elaboration-time geometry helpers.
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Control half of a stage record; the sum chunks and pending operand
  // chunks are sized per stage inside the top level.
  typedef struct packed {
    logic vld;
    logic cry;
  } stage_ctl_t;

  // True when the operand width splits evenly into non-empty slices.
  function automatic bit geometry_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0);
  endfunction

  // Bits handled by each carry slice.
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One CHUNK-bit combinational adder slice of the pipe_adder carry chain.
// With PIPE_ADDER_OVF_EN defined it also exposes the carry into its MSB.
module adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             msb_cin
`endif
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum   = total[CHUNK-1:0];
  assign cout  = total[CHUNK];

`ifdef PIPE_ADDER_OVF_EN
  // The sum bit is a ^ b ^ carry-in, so the MSB carry-in falls out directly.
  assign msb_cin = total[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
`endif

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder built from STAGES registered carry slices with
// valid/ready flow control. The whole pipeline advances as one unit.
// Optional feature: define PIPE_ADDER_OVF_EN to add the registered signed
// overflow output ovf_out.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             valid_out,
  input  logic             ready_in
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Every stage moves together, so the head being stuck stalls everything;
  // ready_out never depends on valid_in.
  logic advance;
  assign advance   = !valid_out || ready_in;
  assign ready_out = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * CHUNK;    // lowest bit this stage adds
    localparam int HI = LO + CHUNK;   // bits of sum complete after this stage

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] s_c;
    logic             c_in;
    logic             c_out;
    logic             vld_src;
    logic [HI-1:0]    sum_d;
    stage_ctl_t       ctl_p;
    logic [HI-1:0]    sum_p;
`ifdef PIPE_ADDER_OVF_EN
    logic             msb_c;
`endif

    if (k == 0) begin : g_src
      assign a_c     = a_in[CHUNK-1:0];
      assign b_c     = b_in[CHUNK-1:0];
      assign c_in    = carry_in;
      assign vld_src = valid_in;
      assign sum_d   = s_c;
    end else begin : g_src
      assign a_c     = g_stg[k-1].g_skew.pa_p[CHUNK-1:0];
      assign b_c     = g_stg[k-1].g_skew.pb_p[CHUNK-1:0];
      assign c_in    = g_stg[k-1].ctl_p.cry;
      assign vld_src = g_stg[k-1].ctl_p.vld;
      assign sum_d   = {s_c, g_stg[k-1].sum_p};
    end

    adder_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .a       (a_c),
      .b       (b_c),
      .cin     (c_in),
      .sum     (s_c),
      .cout    (c_out)
`ifdef PIPE_ADDER_OVF_EN
      ,
      .msb_cin (msb_c)
`endif
    );

    // Upper operand chunks not yet added ride forward with the carry.
    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-HI-1:0] pa_d;
      logic [WIDTH-HI-1:0] pb_d;
      logic [WIDTH-HI-1:0] pa_p;
      logic [WIDTH-HI-1:0] pb_p;

      if (k == 0) begin : g_first
        assign pa_d = a_in[WIDTH-1:HI];
        assign pb_d = b_in[WIDTH-1:HI];
      end else begin : g_first
        assign pa_d = g_stg[k-1].g_skew.pa_p[WIDTH-LO-1:CHUNK];
        assign pb_d = g_stg[k-1].g_skew.pb_p[WIDTH-LO-1:CHUNK];
      end

      // Skew registers: data only, no reset needed.
      always_ff @(posedge clk_in) begin
        if (advance) begin
          pa_p <= pa_d;
          pb_p <= pb_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_reg
`ifdef PIPE_ADDER_OVF_EN
      logic ovf_p;

      // Signed overflow: carry into the MSB disagrees with carry out of it.
      always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
          ovf_p <= 1'b0;
        end else if (advance) begin
          ovf_p <= msb_c ^ c_out;
        end
      end
`endif

      // Output stage: visible registers are cleared so reset shows zeros.
      always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
          ctl_p <= '0;
          sum_p <= '0;
        end else if (advance) begin
          ctl_p.vld <= vld_src;
          ctl_p.cry <= c_out;
          sum_p     <= sum_d;
        end
      end
    end else begin : g_reg
      // Inner stage: only the valid bit is reset; data just follows advance.
      always_ff @(posedge clk_in) begin
        if (advance) begin
          ctl_p.cry <= c_out;
          sum_p     <= sum_d;
        end
        if (!rst_n_in) begin
          ctl_p.vld <= 1'b0;
        end else if (advance) begin
          ctl_p.vld <= vld_src;
        end
      end
    end
  end

  assign valid_out = g_stg[STAGES-1].ctl_p.vld;
  assign carry_out = g_stg[STAGES-1].ctl_p.cry;
  assign sum_out   = g_stg[STAGES-1].sum_p;
`ifdef PIPE_ADDER_OVF_EN
  assign ovf_out   = g_stg[STAGES-1].g_reg.ovf_p;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: a 16-bit/4-stage instance plus 8-bit
// instances with 1 and 8 stages. Define PIPE_ADDER_OVF_EN for ovf_out checks.
module tb_pipe_adder;

  logic clk;
  logic rst_n;

  logic [15:0] a16, b16, s16;
  logic        c16, v16, r16, rdy16, co16, vo16;
  logic [7:0]  a8, b8, s8a, s8b;
  logic        c8, v8, rdy8a, rdy8b, co8a, co8b, vo8a, vo8b;
`ifdef PIPE_ADDER_OVF_EN
  logic        ovf16, ovf8a, ovf8b;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] va [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F,
                          16'h00FF, 16'hABCD, 16'h0000, 16'h7FFF};
  logic [15:0] vb [8] = '{16'h4321, 16'hFFFF, 16'h8000, 16'hF0F0,
                          16'h0001, 16'h1111, 16'h0000, 16'h0001};
  logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  // {carry_out, sum_out}, worked out by hand
  logic [16:0] vr [8] = '{17'h05555, 17'h1FFFF, 17'h10000, 17'h10000,
                          17'h00100, 17'h0BCDE, 17'h00001, 17'h08000};

  pipe_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk_in (clk), .rst_n_in (rst_n), .a_in (a16), .b_in (b16),
    .carry_in (c16), .valid_in (v16), .ready_out (rdy16), .sum_out (s16),
    .carry_out (co16), .valid_out (vo16), .ready_in (r16)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf_out (ovf16)
`endif
  );

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut8a (
    .clk_in (clk), .rst_n_in (rst_n), .a_in (a8), .b_in (b8),
    .carry_in (c8), .valid_in (v8), .ready_out (rdy8a), .sum_out (s8a),
    .carry_out (co8a), .valid_out (vo8a), .ready_in (1'b1)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf_out (ovf8a)
`endif
  );

  pipe_adder #(.WIDTH(8), .STAGES(8)) u_dut8b (
    .clk_in (clk), .rst_n_in (rst_n), .a_in (a8), .b_in (b8),
    .carry_in (c8), .valid_in (v8), .ready_out (rdy8b), .sum_out (s8b),
    .carry_out (co8b), .valid_out (vo8b), .ready_in (1'b1)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf_out (ovf8b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input int i);
    a16 = va[i];
    b16 = vb[i];
    c16 = vc[i];
    v16 = 1'b1;
  endtask

  initial begin
    int nout, ai, ni, seen, first1, first8;
    rst_n = 1'b0;
    a16 = '0; b16 = '0; c16 = 1'b0; v16 = 1'b0; r16 = 1'b1;
    a8 = '0; b8 = '0; c8 = 1'b0; v8 = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_valid", vo16, 0);
    check_eq("rst_sum", s16, 0);
    check_eq("rst_carry", co16, 0);
    check_eq("rst_ready", rdy16, 1);
`ifdef PIPE_ADDER_OVF_EN
    check_eq("rst_ovf", ovf16, 0);
`endif
    rst_n = 1'b1;

    // Single op 0xFFFF + 0x0001: latency 4, one-cycle valid pulse
    a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b0; v16 = 1'b1;
    tick();
    v16 = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      check_eq("single_valid", vo16, (e == 4) ? 1 : 0);
      if (e == 4) check_eq("single_result", {co16, s16}, 17'h10000);
      if (e < 5) tick();
    end

    // Back-to-back stream of 8 operations
    nout = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 8) drive16(cyc);
      else v16 = 1'b0;
      tick();
      check_eq("stream_valid", vo16, (cyc + 1 >= 4 && cyc + 1 <= 11) ? 1 : 0);
      if (vo16 && nout < 8) begin
        check_eq("stream_result", {co16, s16}, vr[nout]);
        nout++;
      end
    end
    check_eq("stream_count", nout, 8);

    // Back-pressure: fill with ready_in low, hold 3 cycles, then drain
    ai = 0;
    ni = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      r16 = (cyc >= 7);
      if (ai < 6) drive16(ai);
      else v16 = 1'b0;
      #1;
      if (cyc == 4) check_eq("bp_accepts", ai, 4);
      if (cyc >= 4 && cyc <= 6) begin
        check_eq("bp_ready_low", rdy16, 0);
        check_eq("bp_valid_held", vo16, 1);
        check_eq("bp_sum_held", {co16, s16}, vr[0]);
      end
      if (vo16 && r16) begin
        if (ni < 6) check_eq("bp_order", {co16, s16}, vr[ni]);
        ni++;
      end
      if (v16 && rdy16) ai++;
      tick();
    end
    check_eq("bp_in_count", ai, 6);
    check_eq("bp_out_count", ni, 6);
    r16 = 1'b1;

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      drive16(i);
      tick();
    end
    drive16(3);
    rst_n = 1'b0;
    tick();
    check_eq("midrst_valid", vo16, 0);
    check_eq("midrst_sum", s16, 0);
    check_eq("midrst_carry", co16, 0);
    check_eq("midrst_ready", rdy16, 1);
    rst_n = 1'b1;
    v16 = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vo16) seen++;
    end
    check_eq("midrst_no_emit", seen, 0);

`ifdef PIPE_ADDER_OVF_EN
    // Signed overflow flag
    a16 = 16'h7FFF; b16 = 16'h0001; c16 = 1'b0; v16 = 1'b1;
    tick();
    a16 = 16'hFFFF; b16 = 16'h0001;
    tick();
    v16 = 1'b0;
    tick();
    tick();
    check_eq("ovf_a_valid", vo16, 1);
    check_eq("ovf_a_result", {co16, s16}, 17'h08000);
    check_eq("ovf_a_flag", ovf16, 1);
    tick();
    check_eq("ovf_b_valid", vo16, 1);
    check_eq("ovf_b_result", {co16, s16}, 17'h10000);
    check_eq("ovf_b_flag", ovf16, 0);
    tick();
`endif

    // STAGES=1 and STAGES=8: 0xAA + 0x55 + 1 = 0x100
    a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    first1 = -1;
    first8 = -1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (vo8a && first1 < 0) begin
        first1 = cyc;
        check_eq("s1_result", {co8a, s8a}, 9'h100);
      end
      if (vo8b && first8 < 0) begin
        first8 = cyc;
        check_eq("s8_result", {co8b, s8b}, 9'h100);
      end
      tick();
    end
    check_eq("s1_latency", first1, 1);
    check_eq("s8_latency", first8, 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
